// File: rtl/neosd_cmd_seq.sv
// neosd_cmd_seq: sequences one SD command through CRC7, register load, FSM start and response collection.
module neosd_cmd_seq #(
   parameter int unsigned TIMEOUT_CYC = 65535
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           req_valid_i,
   output logic           req_ready_o,
   input  logic [5:0]     req_idx_i,
   input  logic [31:0]    req_arg_i,
   input  logic [1:0]     req_rmode_i,
   input  logic [1:0]     req_dmode_i,
   output logic           done_o,
   output logic           err_timeout_o,
   output logic [159:0]   resp_o,
   output logic [2:0]     resp_words_o,
   output logic [5:0]     cmd_idx_o,
   output logic [31:0]    cmd_arg_o,
   output logic [6:0]     cmd_crc_o,
   output logic           cmd_idx_load_o,
   output logic [3:0]     cmd_arg_load_o,
   output logic           cmd_crc_load_o,
   output logic           ctrl_start_o,
   output logic           ctrl_resp_ack_o,
   output logic [1:0]     ctrl_rmode_o,
   output logic [1:0]     ctrl_dmode_o,
   input  logic [31:0]    resp_data_i,
   input  logic           status_idle_i,
   input  logic           status_resp_i
);
   typedef enum logic [2:0] {S_IDLE, S_CRC, S_LOAD, S_START, S_WAIT_RESP, S_ACK, S_WAIT_END, S_DONE} state_t;
   state_t state, state_n;
   logic [5:0]   idx_q, bit_q;
   logic [31:0]  arg_q, tmo_q;
   logic [1:0]   rmode_q, dmode_q;
   logic [6:0]   crc_q;
   logic [2:0]   cnt_q, tgt_q, words_q;
   logic [159:0] resp_q;
   logic         err_q;
   logic [39:0]  frame;
   logic         fb, accept, waiting, tmo_hit;
   always_comb begin
      frame   = {2'b01, idx_q, arg_q};
      fb      = frame[6'd39 - bit_q] ^ crc_q[6];
      accept  = state == S_IDLE && req_valid_i && status_idle_i;
      waiting = state inside {S_START, S_WAIT_RESP, S_ACK, S_WAIT_END};
      tmo_hit = TIMEOUT_CYC != 0 && waiting && tmo_q == TIMEOUT_CYC - 1;
      state_n = state;
      case (state)
         S_IDLE:      state_n = accept ? S_CRC : S_IDLE;
         S_CRC:       state_n = bit_q == 6'd39 ? S_LOAD : S_CRC;
         S_LOAD:      state_n = S_START;
         S_START:     state_n = status_idle_i ? S_START : (rmode_q inside {2'd1, 2'd2}) ? S_WAIT_RESP : S_WAIT_END;
         S_WAIT_RESP: state_n = status_resp_i ? S_ACK : S_WAIT_RESP;
         S_ACK:       state_n = status_resp_i ? S_ACK : cnt_q == tgt_q ? S_DONE : S_WAIT_RESP;
         S_WAIT_END:  state_n = status_idle_i ? S_DONE : S_WAIT_END;
         default:     state_n = S_IDLE;
      endcase
      // The command FSM is left running on timeout; the next accept waits for it to go idle.
      if (tmo_hit) state_n = S_DONE;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= S_IDLE;
         idx_q   <= '0;
         arg_q   <= '0;
         rmode_q <= '0;
         dmode_q <= '0;
         crc_q   <= '0;
         bit_q   <= '0;
         cnt_q   <= '0;
         tgt_q   <= '0;
         words_q <= '0;
         resp_q  <= '0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_n;
         tmo_q <= (state_n != state || !waiting) ? '0 : tmo_q + 1;
         if (accept) begin
            idx_q   <= req_idx_i;
            arg_q   <= req_arg_i;
            rmode_q <= req_rmode_i;
            dmode_q <= req_dmode_i;
            tgt_q   <= req_rmode_i == 2'd1 ? 3'd2 : req_rmode_i == 2'd2 ? 3'd5 : 3'd0;
            resp_q  <= '0;
            cnt_q   <= '0;
            crc_q   <= '0;
            bit_q   <= '0;
         end
         if (state == S_CRC) begin
            crc_q <= {crc_q[5:0], fb} ^ {3'b000, fb, 3'b000};
            bit_q <= bit_q + 6'd1;
         end
         if (state == S_WAIT_RESP && status_resp_i && !tmo_hit) begin
            resp_q <= {resp_q[127:0], resp_data_i};
            cnt_q  <= cnt_q + 3'd1;
         end
         if (state_n == S_DONE && state != S_DONE) begin
            words_q <= cnt_q;
            err_q   <= tmo_hit;
         end
      end
   end
   assign req_ready_o     = state == S_IDLE && status_idle_i;
   assign done_o          = state == S_DONE;
   assign err_timeout_o   = state == S_DONE && err_q;
   assign resp_o          = resp_q;
   assign resp_words_o    = words_q;
   assign cmd_idx_o       = idx_q;
   assign cmd_arg_o       = arg_q;
   assign cmd_crc_o       = crc_q;
   assign cmd_idx_load_o  = state == S_LOAD;
   assign cmd_arg_load_o  = {4{state == S_LOAD}};
   assign cmd_crc_load_o  = state == S_LOAD;
   assign ctrl_start_o    = state == S_START;
   assign ctrl_resp_ack_o = state == S_ACK;
   assign ctrl_rmode_o    = rmode_q;
   assign ctrl_dmode_o    = dmode_q;
endmodule

// File: tb/tb_neosd_cmd_seq.sv
// tb_neosd_cmd_seq: directed checks of neosd_cmd_seq with the command FSM side driven by hand.
module tb_neosd_cmd_seq;
   logic           clk_i = 1'b0;
   logic           rst_i;
   logic           req_valid_i, req_ready_o;
   logic [5:0]     req_idx_i;
   logic [31:0]    req_arg_i;
   logic [1:0]     req_rmode_i, req_dmode_i;
   logic           done_o, err_timeout_o;
   logic [159:0]   resp_o;
   logic [2:0]     resp_words_o;
   logic [5:0]     cmd_idx_o;
   logic [31:0]    cmd_arg_o;
   logic [6:0]     cmd_crc_o;
   logic           cmd_idx_load_o, cmd_crc_load_o;
   logic [3:0]     cmd_arg_load_o;
   logic           ctrl_start_o, ctrl_resp_ack_o;
   logic [1:0]     ctrl_rmode_o, ctrl_dmode_o;
   logic [31:0]    resp_data_i;
   logic           status_idle_i, status_resp_i;
   int checks = 0, errors = 0;
   int n, acks;
   logic [31:0] w [5];

   neosd_cmd_seq #(.TIMEOUT_CYC(100)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_idx_i(req_idx_i), .req_arg_i(req_arg_i),
      .req_rmode_i(req_rmode_i), .req_dmode_i(req_dmode_i),
      .done_o(done_o), .err_timeout_o(err_timeout_o),
      .resp_o(resp_o), .resp_words_o(resp_words_o),
      .cmd_idx_o(cmd_idx_o), .cmd_arg_o(cmd_arg_o), .cmd_crc_o(cmd_crc_o),
      .cmd_idx_load_o(cmd_idx_load_o), .cmd_arg_load_o(cmd_arg_load_o), .cmd_crc_load_o(cmd_crc_load_o),
      .ctrl_start_o(ctrl_start_o), .ctrl_resp_ack_o(ctrl_resp_ack_o),
      .ctrl_rmode_o(ctrl_rmode_o), .ctrl_dmode_o(ctrl_dmode_o),
      .resp_data_i(resp_data_i), .status_idle_i(status_idle_i), .status_resp_i(status_resp_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference CRC7 (x^7+x^3+1) over a 40-bit frame, MSB first.
   function automatic logic [6:0] crc7(input logic [39:0] f);
      logic [6:0] c;
      logic b;
      c = '0;
      for (int i = 39; i >= 0; i--) begin
         b = f[i] ^ c[6];
         c = {c[5:0], 1'b0} ^ (b ? 7'h09 : 7'h00);
      end
      return c;
   endfunction

   // Presents one request, accepts it, and counts cycles until the load strobe.
   task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rm, input logic [1:0] dm, output int cyc);
      req_idx_i = idx; req_arg_i = arg; req_rmode_i = rm; req_dmode_i = dm; req_valid_i = 1'b1;
      tick();
      req_valid_i = 1'b0;
      for (cyc = 0; cyc < 100 && !cmd_idx_load_o; cyc++) tick();
   endtask

   initial begin
      rst_i = 1'b1; req_valid_i = 1'b0; req_idx_i = '0; req_arg_i = '0; req_rmode_i = '0; req_dmode_i = '0;
      resp_data_i = '0; status_idle_i = 1'b1; status_resp_i = 1'b0;
      w[0] = 32'hA1B2_C3D4; w[1] = 32'h1122_3344; w[2] = 32'hDEAD_BEEF; w[3] = 32'h0F0F_F0F0; w[4] = 32'h5555_AAAA;
      tick(); tick();
      chk("rst_ready", req_ready_o, 1'b1);
      chk("rst_done", done_o, 1'b0);
      chk("rst_start", ctrl_start_o, 1'b0);
      chk("rst_resp", resp_o, '0);
      chk("rst_words", resp_words_o, 3'd0);
      status_idle_i = 1'b0; #1;
      chk("rst_ready_busy", req_ready_o, 1'b0);
      status_idle_i = 1'b1; rst_i = 1'b0;
      tick();
      // CMD0, no response
      issue(6'd0, 32'h0, 2'd0, 2'd0, n);
      chk("cmd0_crc_cycles", n, 40);
      chk("cmd0_crc", cmd_crc_o, 7'h4A);
      chk("cmd0_loads", {cmd_idx_load_o, cmd_arg_load_o, cmd_crc_load_o, ctrl_start_o}, 7'b1111110);
      tick();
      chk("cmd0_loads_off", {cmd_idx_load_o, cmd_arg_load_o, cmd_crc_load_o}, 6'b0);
      chk("cmd0_start", ctrl_start_o, 1'b1);
      tick(); tick(); tick();
      chk("cmd0_start_held", ctrl_start_o, 1'b1);
      status_idle_i = 1'b0;
      tick();
      chk("cmd0_start_drop", ctrl_start_o, 1'b0);
      chk("cmd0_no_done_busy", done_o, 1'b0);
      status_idle_i = 1'b1;
      tick();
      chk("cmd0_done", {done_o, err_timeout_o, resp_words_o}, {1'b1, 1'b0, 3'd0});
      tick();
      chk("cmd0_done_pulse", {done_o, req_ready_o}, 2'b01);
      // CMD8, short response
      issue(6'd8, 32'h0000_01AA, 2'd1, 2'd0, n);
      chk("cmd8_crc", cmd_crc_o, 7'h43);
      chk("cmd8_rmode", ctrl_rmode_o, 2'd1);
      tick();
      status_idle_i = 1'b0;
      tick();
      chk("cmd8_start_drop", ctrl_start_o, 1'b0);
      resp_data_i = 32'h0000_0801; status_resp_i = 1'b1;
      tick();
      chk("cmd8_ack0", {ctrl_resp_ack_o, ctrl_start_o}, 2'b10);
      tick();
      chk("cmd8_ack0_held", ctrl_resp_ack_o, 1'b1);
      status_resp_i = 1'b0;
      tick();
      chk("cmd8_ack0_drop", {ctrl_resp_ack_o, done_o}, 2'b00);
      resp_data_i = 32'h0000_01AA; status_resp_i = 1'b1;
      tick();
      chk("cmd8_ack1", ctrl_resp_ack_o, 1'b1);
      status_resp_i = 1'b0;
      tick();
      chk("cmd8_done", {done_o, err_timeout_o, resp_words_o}, {1'b1, 1'b0, 3'd2});
      chk("cmd8_resp", resp_o[63:0], 64'h0000_0801_0000_01AA);
      status_idle_i = 1'b1;
      tick();
      // CMD2, long response
      issue(6'd2, 32'h0, 2'd2, 2'd2, n);
      chk("cmd2_crc", cmd_crc_o, crc7({2'b01, 6'd2, 32'h0}));
      chk("cmd2_modes", {ctrl_rmode_o, ctrl_dmode_o}, 4'b1010);
      tick();
      status_idle_i = 1'b0;
      tick();
      acks = 0;
      for (int i = 0; i < 5; i++) begin
         resp_data_i = w[i]; status_resp_i = 1'b1;
         tick();
         if (ctrl_resp_ack_o) acks++;
         status_resp_i = 1'b0;
         tick();
         if (i < 4) chk("cmd2_no_early_done", done_o, 1'b0);
      end
      chk("cmd2_acks", acks, 5);
      chk("cmd2_done", {done_o, err_timeout_o, resp_words_o}, {1'b1, 1'b0, 3'd5});
      chk("cmd2_resp", resp_o, {w[0], w[1], w[2], w[3], w[4]});
      chk("cmd2_dmode_stable", ctrl_dmode_o, 2'd2);
      status_idle_i = 1'b1;
      tick();
      // Timeout in WAIT_RESP
      issue(6'd8, 32'h0000_01AA, 2'd1, 2'd1, n);
      tick();
      status_idle_i = 1'b0;
      tick();
      chk("tmo_in_wait", ctrl_start_o, 1'b0);
      for (n = 0; n < 200 && !done_o; n++) tick();
      chk("tmo_cycles", n, 100);
      chk("tmo_done", {done_o, err_timeout_o, resp_words_o}, {1'b1, 1'b1, 3'd0});
      tick();
      // Request while the FSM is still busy
      req_idx_i = 6'd17; req_arg_i = 32'h1234_5678; req_rmode_i = 2'd1; req_dmode_i = 2'd2; req_valid_i = 1'b1;
      #1;
      chk("busy_ready", req_ready_o, 1'b0);
      for (int i = 0; i < 45; i++) begin
         tick();
         if (cmd_idx_load_o || req_ready_o) chk("busy_no_accept", {cmd_idx_load_o, req_ready_o}, 2'b00);
      end
      chk("busy_idle_out", {done_o, cmd_idx_load_o}, 2'b00);
      status_idle_i = 1'b1; #1;
      chk("idle_ready", req_ready_o, 1'b1);
      tick();
      chk("accepted_ready", req_ready_o, 1'b0);
      tick(); tick();
      chk("crc_busy_ready", req_ready_o, 1'b0);
      req_valid_i = 1'b0;
      for (n = 0; n < 100 && !cmd_idx_load_o; n++) tick();
      chk("rst_cmd_load", {cmd_idx_load_o, cmd_arg_o}, {1'b1, 32'h1234_5678});
      tick();
      status_idle_i = 1'b0;
      tick();
      resp_data_i = 32'hCAFE_F00D; status_resp_i = 1'b1;
      tick();
      chk("rst_in_ack", ctrl_resp_ack_o, 1'b1);
      rst_i = 1'b1;
      tick();
      chk("rst_ack_low", {ctrl_resp_ack_o, ctrl_start_o, done_o, err_timeout_o}, 4'b0);
      chk("rst_regs", {resp_o, resp_words_o, cmd_idx_o, cmd_arg_o, cmd_crc_o}, '0);
      chk("rst_ctrl", {ctrl_rmode_o, ctrl_dmode_o, cmd_arg_load_o, req_ready_o}, 9'b0);
      rst_i = 1'b0; status_resp_i = 1'b0; status_idle_i = 1'b1;
      tick();
      chk("final_ready", req_ready_o, 1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
